// File: rtl/hwt_pkg.sv
// Shared definitions for the hwt sequential trigger: FSM state encoding and
// default counter width.
package hwt_pkg;

  localparam int HWT_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_COUNT = 2'b10,
    ST_FIRED = 2'b11
  } hwt_state_e;

endpackage

// File: rtl/hwt_hit_vec.sv
// Per-channel combinational hwt function, bit-identical to the legacy
// 4-input hwt cell replicated WIDTH times.
module hwt_hit_vec #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] hit
);

  assign hit = d & (c ^ (a & b));

endmodule

// File: rtl/hwt_seq_trigger.sv
// Registered multi-channel hwt hit vector feeding an armed, count-qualified
// trigger FSM.
//
//   state | meaning
//   IDLE  | waiting for arm; all other inputs ignored
//   ARMED | threshold captured, waiting for first match (thr_q==0 parks here)
//   COUNT | counting match cycles toward thr_q
//   FIRED | threshold reached; fire asserted
module hwt_seq_trigger
  import hwt_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CNT_W       = HWT_CNT_W_DEFAULT,
  parameter bit          MATCH_ALL   = 1'b0,
  parameter bit          CONSECUTIVE = 1'b1,
  parameter bit          STICKY      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             arm,
  input  logic             clear,
  input  logic [CNT_W-1:0] thresh,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] hit_q,
  output logic             y,
  output logic             fire,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] hit_comb;
  logic             match;
  hwt_state_e       state_q, state_n;
  logic [CNT_W-1:0] count_n, thr_q, thr_n, count_inc;
  logic             fire_n;

  hwt_hit_vec #(.WIDTH(WIDTH)) u_hit_vec (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .hit (hit_comb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
      y     <= 1'b0;
    end else begin
      hit_q <= en ? hit_comb : '0;
      y     <= en ? (|hit_comb) : 1'b0;
    end
  end

  assign match     = MATCH_ALL ? (&hit_q) : (|hit_q);
  assign count_inc = count + CNT_W'(1);

  always_comb begin
    state_n = state_q;
    count_n = count;
    thr_n   = thr_q;
    fire_n  = fire;
    if (clear) begin
      state_n = ST_IDLE;
      count_n = '0;
      fire_n  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_n = ST_ARMED;
            thr_n   = thresh;
            count_n = '0;
            fire_n  = 1'b0;
          end
        end
        ST_ARMED: begin
          if (match && thr_q != '0) begin
            count_n = CNT_W'(1);
            if (thr_q == CNT_W'(1)) begin
              state_n = ST_FIRED;
              fire_n  = 1'b1;
            end else begin
              state_n = ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (match) begin
            count_n = count_inc;
            if (count_inc == thr_q) begin
              state_n = ST_FIRED;
              fire_n  = 1'b1;
            end
          end else if (CONSECUTIVE) begin
            state_n = ST_ARMED;
            count_n = '0;
          end
        end
        ST_FIRED: begin
          fire_n = 1'b1;
          // Non-sticky: single-cycle pulse, then re-arm with the same threshold.
          if (!STICKY) begin
            state_n = ST_ARMED;
            count_n = '0;
            fire_n  = 1'b0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          count_n = '0;
          fire_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count   <= '0;
      thr_q   <= '0;
      fire    <= 1'b0;
    end else begin
      state_q <= state_n;
      count   <= count_n;
      thr_q   <= thr_n;
      fire    <= fire_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hwt_seq_trigger.sv
// Scoreboard bench for hwt_seq_trigger: three parameter variants share stimulus;
// each expectation names the instance it checks.
module tb_hwt_seq_trigger;

  typedef struct {
    int         sel;
    logic [3:0] hit;
    logic       y;
    logic       fire;
    logic [1:0] st;
    logic [7:0] cnt;
    string      nm;
  } exp_t;

  logic       clk, rst, en, arm, clear;
  logic [7:0] thresh;
  logic [3:0] a, b, c, d;

  logic [3:0] hq0, hq1, hq2;
  logic       y0, y1, y2, f0, f1, f2;
  logic [1:0] s0, s1, s2;
  logic [7:0] c0, c1, c2;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  hwt_seq_trigger #(.WIDTH(4), .CNT_W(8), .MATCH_ALL(1'b0), .CONSECUTIVE(1'b1), .STICKY(1'b1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .arm(arm), .clear(clear), .thresh(thresh),
    .a(a), .b(b), .c(c), .d(d),
    .hit_q(hq0), .y(y0), .fire(f0), .state(s0), .count(c0)
  );

  hwt_seq_trigger #(.WIDTH(4), .CNT_W(8), .MATCH_ALL(1'b1), .CONSECUTIVE(1'b1), .STICKY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .arm(arm), .clear(clear), .thresh(thresh),
    .a(a), .b(b), .c(c), .d(d),
    .hit_q(hq1), .y(y1), .fire(f1), .state(s1), .count(c1)
  );

  hwt_seq_trigger #(.WIDTH(4), .CNT_W(8), .MATCH_ALL(1'b0), .CONSECUTIVE(1'b1), .STICKY(1'b0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .arm(arm), .clear(clear), .thresh(thresh),
    .a(a), .b(b), .c(c), .d(d),
    .hit_q(hq2), .y(y2), .fire(f2), .state(s2), .count(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drains the scoreboard on every falling edge.
  exp_t       m_e;
  logic [3:0] m_h;
  logic       m_y, m_f;
  logic [1:0] m_s;
  logic [7:0] m_c;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      case (m_e.sel)
        0:       begin m_h = hq0; m_y = y0; m_f = f0; m_s = s0; m_c = c0; end
        1:       begin m_h = hq1; m_y = y1; m_f = f1; m_s = s1; m_c = c1; end
        default: begin m_h = hq2; m_y = y2; m_f = f2; m_s = s2; m_c = c2; end
      endcase
      n_cmp++;
      if ({m_h, m_y, m_f, m_s, m_c} !== {m_e.hit, m_e.y, m_e.fire, m_e.st, m_e.cnt}) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got hit_q=%h y=%b fire=%b state=%0d count=%0d, want hit_q=%h y=%b fire=%b state=%0d count=%0d",
                 m_e.nm, m_e.sel, m_h, m_y, m_f, m_s, m_c,
                 m_e.hit, m_e.y, m_e.fire, m_e.st, m_e.cnt);
      end
    end
  end

  task automatic push(input int s, input logic [3:0] eh, input logic ef,
                      input logic [1:0] es, input logic [7:0] ec, input string nm);
    exp_t e;
    e.sel = s; e.hit = eh; e.y = |eh; e.fire = ef; e.st = es; e.cnt = ec; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic tick(input int s, input logic [3:0] eh, input logic ef,
                      input logic [1:0] es, input logic [7:0] ec, input string nm);
    @(posedge clk);
    push(s, eh, ef, es, ec, nm);
    @(negedge clk);
  endtask

  task automatic hin(input logic [3:0] cv, input logic [3:0] dv);
    a = 4'h0; b = 4'h0; c = cv; d = dv;
  endtask

  logic [15:0] tt;
  logic [3:0]  iv;

  initial begin
    rst = 1'b1; en = 1'b1; arm = 1'b0; clear = 1'b0; thresh = 8'd0;
    hin(4'h0, 4'h0);
    tt = 16'h2888;  // hwt truth table indexed by {a,b,c,d}
    push(0, 4'h0, 1'b0, 2'd0, 8'd0, "reset");
    push(1, 4'h0, 1'b0, 2'd0, 8'd0, "reset");
    push(2, 4'h0, 1'b0, 2'd0, 8'd0, "reset");
    @(negedge clk);
    rst = 1'b0;

    // Truth table on channel 0
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      a = {3'b0, iv[3]}; b = {3'b0, iv[2]}; c = {3'b0, iv[1]}; d = {3'b0, iv[0]};
      tick(0, {3'b0, tt[i]}, 1'b0, 2'd0, 8'd0, "truth_table");
    end
    hin(4'hF, 4'hF); en = 1'b0;
    tick(0, 4'h0, 1'b0, 2'd0, 8'd0, "en_low");
    en = 1'b1;
    tick(0, 4'hF, 1'b0, 2'd0, 8'd0, "en_high");
    hin(4'h0, 4'h0);
    tick(0, 4'h0, 1'b0, 2'd0, 8'd0, "idle_zero");

    // Threshold 3, consecutive matches, sticky fire
    hin(4'h1, 4'h1); arm = 1'b1; thresh = 8'd3;
    tick(0, 4'h1, 1'b0, 2'd1, 8'd0, "t3_arm");
    arm = 1'b0;
    tick(0, 4'h1, 1'b0, 2'd2, 8'd1, "t3_m1");
    tick(0, 4'h1, 1'b0, 2'd2, 8'd2, "t3_m2");
    tick(0, 4'h1, 1'b1, 2'd3, 8'd3, "t3_fire");
    hin(4'h0, 4'h0);
    tick(0, 4'h0, 1'b1, 2'd3, 8'd3, "t3_sticky");
    clear = 1'b1;
    tick(0, 4'h0, 1'b0, 2'd0, 8'd0, "t3_clear");
    clear = 1'b0;

    // Threshold 4 with a gap; arm while counting must not reload thr_q
    hin(4'h1, 4'h1); arm = 1'b1; thresh = 8'd4;
    tick(0, 4'h1, 1'b0, 2'd1, 8'd0, "gap_arm");
    arm = 1'b0;
    tick(0, 4'h1, 1'b0, 2'd2, 8'd1, "gap_m1");
    hin(4'h0, 4'h0); arm = 1'b1; thresh = 8'd1;
    tick(0, 4'h0, 1'b0, 2'd2, 8'd2, "gap_m2");
    arm = 1'b0; hin(4'h1, 4'h1);
    tick(0, 4'h1, 1'b0, 2'd1, 8'd0, "gap_reset");
    tick(0, 4'h1, 1'b0, 2'd2, 8'd1, "gap_m1_again");
    clear = 1'b1; hin(4'h0, 4'h0);
    tick(0, 4'h0, 1'b0, 2'd0, 8'd0, "gap_clear");
    clear = 1'b0;

    // Threshold 0 parks in ARMED
    hin(4'h1, 4'h1); arm = 1'b1; thresh = 8'd0;
    tick(0, 4'h1, 1'b0, 2'd1, 8'd0, "thr0_arm");
    arm = 1'b0;
    repeat (3) tick(0, 4'h1, 1'b0, 2'd1, 8'd0, "thr0_hold");
    clear = 1'b1;
    tick(0, 4'h1, 1'b0, 2'd0, 8'd0, "thr0_clear");
    clear = 1'b0;

    // Threshold 255
    arm = 1'b1; thresh = 8'd255;
    tick(0, 4'h1, 1'b0, 2'd1, 8'd0, "thr255_arm");
    arm = 1'b0;
    for (int k = 1; k <= 254; k++) tick(0, 4'h1, 1'b0, 2'd2, 8'(k), "thr255_count");
    tick(0, 4'h1, 1'b1, 2'd3, 8'd255, "thr255_fire");
    tick(0, 4'h1, 1'b1, 2'd3, 8'd255, "thr255_hold");
    clear = 1'b1;
    tick(0, 4'h1, 1'b0, 2'd0, 8'd0, "thr255_clear");
    clear = 1'b0;

    // MATCH_ALL instance: 0111 never matches, 1111 fires with thresh 1
    hin(4'h0, 4'h0); clear = 1'b1;
    tick(1, 4'h0, 1'b0, 2'd0, 8'd0, "all_clear");
    clear = 1'b0;
    hin(4'h7, 4'hF); arm = 1'b1; thresh = 8'd1;
    tick(1, 4'h7, 1'b0, 2'd1, 8'd0, "all_arm");
    arm = 1'b0;
    repeat (4) tick(1, 4'h7, 1'b0, 2'd1, 8'd0, "all_partial");
    hin(4'hF, 4'hF);
    tick(1, 4'hF, 1'b0, 2'd1, 8'd0, "all_full_in");
    tick(1, 4'hF, 1'b1, 2'd3, 8'd1, "all_fire");
    hin(4'h0, 4'h0); clear = 1'b1;
    tick(1, 4'h0, 1'b0, 2'd0, 8'd0, "all_clear2");
    clear = 1'b0;

    // Non-sticky instance, threshold 2, continuous match
    hin(4'h1, 4'h1); clear = 1'b1;
    tick(2, 4'h1, 1'b0, 2'd0, 8'd0, "pulse_clear");
    clear = 1'b0; arm = 1'b1; thresh = 8'd2;
    tick(2, 4'h1, 1'b0, 2'd1, 8'd0, "pulse_arm");
    arm = 1'b0;
    tick(2, 4'h1, 1'b0, 2'd2, 8'd1, "pulse_m1");
    tick(2, 4'h1, 1'b1, 2'd3, 8'd2, "pulse_fire1");
    tick(2, 4'h1, 1'b0, 2'd1, 8'd0, "pulse_rearm1");
    tick(2, 4'h1, 1'b0, 2'd2, 8'd1, "pulse_m1b");
    tick(2, 4'h1, 1'b1, 2'd3, 8'd2, "pulse_fire2");
    tick(2, 4'h1, 1'b0, 2'd1, 8'd0, "pulse_rearm2");
    clear = 1'b1;
    tick(2, 4'h1, 1'b0, 2'd0, 8'd0, "pulse_clear2");
    clear = 1'b0;

    // Async reset mid-count
    clear = 1'b1;
    tick(0, 4'h1, 1'b0, 2'd0, 8'd0, "rst_preclear");
    clear = 1'b0; arm = 1'b1; thresh = 8'd10;
    tick(0, 4'h1, 1'b0, 2'd1, 8'd0, "rst_arm");
    arm = 1'b0;
    for (int k = 1; k <= 5; k++) tick(0, 4'h1, 1'b0, 2'd2, 8'(k), "rst_count");
    @(posedge clk);
    #2 rst = 1'b1;
    push(0, 4'h0, 1'b0, 2'd0, 8'd0, "rst_async");
    @(negedge clk);
    rst = 1'b0;
    tick(0, 4'h1, 1'b0, 2'd0, 8'd0, "rst_needs_arm");
    tick(0, 4'h1, 1'b0, 2'd0, 8'd0, "rst_needs_arm2");

    // clear beats arm in the same cycle
    clear = 1'b1; arm = 1'b1; thresh = 8'd1;
    tick(0, 4'h1, 1'b0, 2'd0, 8'd0, "clear_arm");
    clear = 1'b0; arm = 1'b0;
    tick(0, 4'h1, 1'b0, 2'd0, 8'd0, "clear_arm_after");

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "timeout");
  end

endmodule
